// File: rtl/imsic_topei_scanner_if.sv
// Request/result handshake plus shared read port of the eip/eie RAM pair.
// master = requester and RAM side, slave = scanner.
interface imsic_topei_scanner_if #(
  parameter int AddrBits = 5,
  parameter int IdBits   = 10
);
  logic                scan_req;
  logic [IdBits-1:0]   threshold;
  logic [AddrBits-1:0] raddr;
  logic [31:0]         eip_rd;
  logic [31:0]         eie_rd;
  logic                busy;
  logic                done;
  logic [IdBits-1:0]   topei;
  logic                topei_valid;

  modport master (
    output scan_req, threshold, eip_rd, eie_rd,
    input  raddr, busy, done, topei, topei_valid
  );

  modport slave (
    input  scan_req, threshold, eip_rd, eie_rd,
    output raddr, busy, done, topei, topei_valid
  );
endinterface

// File: rtl/imsic_topei_scanner.sv
// Walks the eip/eie word arrays in ascending order and reports the lowest pending+enabled ID below threshold.
// Hit in word k: done k+3 cycles after the request; miss: NumWords+2. Requests while busy fold into one rescan.
module imsic_topei_scanner #(
  parameter int NumWords = 32,
  parameter int AddrBits = 5,
  parameter int IdBits   = 10
) (
  input  logic                       clk,
  input  logic                       rstn,
  imsic_topei_scanner_if.slave       bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  localparam logic [AddrBits-1:0] LastAddr = AddrBits'(NumWords - 1);

  state_e              state_q, state_d;
  logic [IdBits-1:0]   thr_q, thr_d;
  logic                rescan_q, rescan_d;
  logic [AddrBits-1:0] cnt_q, cnt_d;
  logic                dv_q, dv_d;
  logic [AddrBits-1:0] didx_q, didx_d;
  logic [IdBits-1:0]   topei_q, topei_d;
  logic                topei_valid_q, topei_valid_d;

  logic [31:0] hits;
  logic [4:0]  low_bit;
  logic        hit_any;

  // ID 0 is never a valid identity; IDs at or above a nonzero threshold are suppressed.
  always_comb begin
    hits = bus.eip_rd & bus.eie_rd;
    for (int b = 0; b < 32; b++) begin
      if ((didx_q == '0) && (b == 0)) hits[b] = 1'b0;
      if ((thr_q != '0) && ({didx_q, 5'(b)} >= thr_q)) hits[b] = 1'b0;
    end
    low_bit = '0;
    hit_any = 1'b0;
    for (int b = 31; b >= 0; b--) begin
      if (hits[b]) begin
        low_bit = 5'(b);
        hit_any = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    thr_d         = thr_q;
    rescan_d      = rescan_q;
    cnt_d         = cnt_q;
    dv_d          = 1'b0;
    didx_d        = didx_q;
    topei_d       = topei_q;
    topei_valid_d = topei_valid_q;

    case (state_q)
      IDLE: begin
        if (bus.scan_req || rescan_q) begin
          state_d  = SCAN;
          thr_d    = bus.threshold;
          rescan_d = 1'b0;
          cnt_d    = '0;
        end
      end
      SCAN: begin
        if (bus.scan_req) rescan_d = 1'b1;
        // dv/didx follow the address by one cycle to line up with the RAM's registered output.
        dv_d   = 1'b1;
        didx_d = cnt_q;
        if (cnt_q != LastAddr) cnt_d = cnt_q + 1'b1;
        if (dv_q && hit_any) begin
          topei_d       = {didx_q, low_bit};
          topei_valid_d = 1'b1;
          state_d       = DONE;
          dv_d          = 1'b0;
          cnt_d         = cnt_q;
        end else if (dv_q && (didx_q == LastAddr)) begin
          topei_d       = '0;
          topei_valid_d = 1'b0;
          state_d       = DONE;
          dv_d          = 1'b0;
          cnt_d         = cnt_q;
        end
      end
      DONE: begin
        if (bus.scan_req) rescan_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      thr_q         <= '0;
      rescan_q      <= 1'b0;
      cnt_q         <= '0;
      dv_q          <= 1'b0;
      didx_q        <= '0;
      topei_q       <= '0;
      topei_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      thr_q         <= thr_d;
      rescan_q      <= rescan_d;
      cnt_q         <= cnt_d;
      dv_q          <= dv_d;
      didx_q        <= didx_d;
      topei_q       <= topei_d;
      topei_valid_q <= topei_valid_d;
    end
  end

  assign bus.raddr       = cnt_q;
  assign bus.busy        = (state_q == SCAN);
  assign bus.done        = (state_q == DONE);
  assign bus.topei       = topei_q;
  assign bus.topei_valid = topei_valid_q;

endmodule

// File: tb/tb_imsic_topei_scanner.sv
// Directed bench for imsic_topei_scanner with a behavioural 1-cycle registered RAM pair.
module tb_imsic_topei_scanner;

  localparam int NumWords = 32;
  localparam int AddrBits = 5;
  localparam int IdBits   = 10;

  logic clk;
  logic rstn;
  int   nvec;
  int   nerr;

  logic [31:0] eip_mem [NumWords];
  logic [31:0] eie_mem [NumWords];

  imsic_topei_scanner_if #(.AddrBits(AddrBits), .IdBits(IdBits)) bus ();

  imsic_topei_scanner #(
    .NumWords(NumWords),
    .AddrBits(AddrBits),
    .IdBits  (IdBits)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus.eip_rd <= eip_mem[bus.raddr];
    bus.eie_rd <= eie_mem[bus.raddr];
  end

  task automatic clear_mem();
    for (int i = 0; i < NumWords; i++) begin
      eip_mem[i] = 32'h0;
      eie_mem[i] = 32'h0;
    end
  endtask

  // Request in cycle 0; returns the cycle of the done pulse (-1 on timeout) and the peak raddr.
  task automatic run_scan(output int done_cyc, output int max_ra);
    int c;
    done_cyc = -1;
    max_ra   = 0;
    @(negedge clk);
    bus.scan_req = 1'b1;
    @(negedge clk);
    bus.scan_req = 1'b0;
    c = 1;
    while ((c < 200) && (done_cyc < 0)) begin
      if (int'(bus.raddr) > max_ra) max_ra = int'(bus.raddr);
      if (bus.done) done_cyc = c;
      else begin
        @(negedge clk);
        c++;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    nvec++;
    if ({bus.busy, bus.done, bus.topei_valid} !== 3'b000) begin
      nerr++;
      $display("FAIL reset_flags: got busy/done/valid=%b, expected 000", {bus.busy, bus.done, bus.topei_valid});
    end
    nvec++;
    if (bus.topei !== 10'd0) begin
      nerr++;
      $display("FAIL reset_topei: got %0d, expected 0", bus.topei);
    end
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    nvec++;
    if ({bus.busy, bus.done, bus.topei_valid, bus.raddr} !== 8'd0) begin
      nerr++;
      $display("FAIL idle_no_req: got busy/done/valid/raddr=%b, expected all 0",
               {bus.busy, bus.done, bus.topei_valid, bus.raddr});
    end
  endtask

  task automatic test_id0_masked();
    int dc, mr;
    clear_mem();
    eip_mem[0] = 32'h0000_0001;
    for (int i = 0; i < NumWords; i++) eie_mem[i] = 32'hFFFF_FFFF;
    bus.threshold = '0;
    run_scan(dc, mr);
    nvec++;
    if (dc !== 34) begin
      nerr++;
      $display("FAIL id0_done_cycle: got %0d, expected 34", dc);
    end
    nvec++;
    if ({bus.topei_valid, bus.topei} !== 11'd0) begin
      nerr++;
      $display("FAIL id0_topei: got valid=%0d topei=%0d, expected 0/0", bus.topei_valid, bus.topei);
    end
  endtask

  task automatic test_hit_word2();
    int dc, mr;
    clear_mem();
    eip_mem[2] = 32'h0001_0100;
    eie_mem[2] = 32'h0001_0100;
    bus.threshold = '0;
    run_scan(dc, mr);
    nvec++;
    if (dc !== 5) begin
      nerr++;
      $display("FAIL w2_done_cycle: got %0d, expected 5", dc);
    end
    nvec++;
    if ((bus.topei !== 10'd72) || (bus.topei_valid !== 1'b1)) begin
      nerr++;
      $display("FAIL w2_topei: got %0d valid=%0d, expected 72 valid=1", bus.topei, bus.topei_valid);
    end
    nvec++;
    if (mr !== 3) begin
      nerr++;
      $display("FAIL w2_max_raddr: got %0d, expected 3", mr);
    end
  endtask

  task automatic test_threshold();
    int dc, mr;
    int thr_tab [3] = '{70, 73, 72};
    int id_tab  [3] = '{0, 72, 0};
    int cyc_tab [3] = '{34, 5, 34};
    for (int t = 0; t < 3; t++) begin
      bus.threshold = IdBits'(thr_tab[t]);
      run_scan(dc, mr);
      nvec++;
      if (dc !== cyc_tab[t]) begin
        nerr++;
        $display("FAIL thr%0d_done_cycle: got %0d, expected %0d", thr_tab[t], dc, cyc_tab[t]);
      end
      nvec++;
      if ((int'(bus.topei) !== id_tab[t]) || (bus.topei_valid !== (id_tab[t] != 0))) begin
        nerr++;
        $display("FAIL thr%0d_topei: got %0d valid=%0d, expected %0d", thr_tab[t], bus.topei,
                 bus.topei_valid, id_tab[t]);
      end
    end
    bus.threshold = '0;
  endtask

  task automatic test_high_id();
    int dc, mr;
    clear_mem();
    eip_mem[5]  = 32'h0000_0008;
    eip_mem[31] = 32'h8000_0000;
    eie_mem[31] = 32'h8000_0000;
    bus.threshold = '0;
    run_scan(dc, mr);
    nvec++;
    if (dc !== 34) begin
      nerr++;
      $display("FAIL high_done_cycle: got %0d, expected 34", dc);
    end
    nvec++;
    if ((bus.topei !== 10'd1023) || (bus.topei_valid !== 1'b1)) begin
      nerr++;
      $display("FAIL high_topei: got %0d valid=%0d, expected 1023 valid=1", bus.topei, bus.topei_valid);
    end
  endtask

  task automatic test_back_to_back();
    int first_c, second_c, ndone;
    logic [IdBits-1:0] first_t, second_t;
    logic idle_busy, restart_busy;
    clear_mem();
    eip_mem[2] = 32'h0000_0100;
    eie_mem[2] = 32'h0000_0100;
    bus.threshold = '0;
    first_c = -1; second_c = -1; ndone = 0;
    first_t = '0; second_t = '0;
    idle_busy = 1'b1; restart_busy = 1'b0;
    @(negedge clk);
    bus.scan_req = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        if (first_c < 0) begin
          first_c = c;
          first_t = bus.topei;
        end else begin
          second_c = c;
          second_t = bus.topei;
        end
      end
      if (c == 6) idle_busy = bus.busy | bus.done;
      if (c == 7) restart_busy = bus.busy;
      bus.scan_req = (c >= 3) && (c <= 5);
      if (c == 3) begin
        eip_mem[1] = 32'h0000_0010;
        eie_mem[1] = 32'h0000_0010;
      end
    end
    bus.scan_req = 1'b0;
    nvec++;
    if ((first_c !== 5) || (first_t !== 10'd72)) begin
      nerr++;
      $display("FAIL b2b_first: got cycle %0d topei %0d, expected cycle 5 topei 72", first_c, first_t);
    end
    nvec++;
    if ((second_c !== 10) || (second_t !== 10'd36)) begin
      nerr++;
      $display("FAIL b2b_second: got cycle %0d topei %0d, expected cycle 10 topei 36", second_c, second_t);
    end
    nvec++;
    if ((idle_busy !== 1'b0) || (restart_busy !== 1'b1)) begin
      nerr++;
      $display("FAIL b2b_idle_gap: got idle busy=%0d restart busy=%0d, expected 0/1", idle_busy, restart_busy);
    end
    nvec++;
    if (ndone !== 2) begin
      nerr++;
      $display("FAIL b2b_done_count: got %0d, expected 2", ndone);
    end
  endtask

  task automatic test_reset_mid_scan();
    int ndone;
    clear_mem();
    @(negedge clk);
    bus.scan_req = 1'b1;
    @(negedge clk);
    bus.scan_req = 1'b0;
    repeat (9) @(negedge clk);
    nvec++;
    if (bus.busy !== 1'b1) begin
      nerr++;
      $display("FAIL midrst_busy_before: got %0d, expected 1", bus.busy);
    end
    rstn = 1'b0;
    #1;
    nvec++;
    if ({bus.busy, bus.done, bus.topei_valid, bus.raddr} !== 8'd0) begin
      nerr++;
      $display("FAIL midrst_flags: got busy/done/valid/raddr=%b, expected all 0",
               {bus.busy, bus.done, bus.topei_valid, bus.raddr});
    end
    nvec++;
    if (bus.topei !== 10'd0) begin
      nerr++;
      $display("FAIL midrst_topei: got %0d, expected 0", bus.topei);
    end
    @(negedge clk);
    rstn = 1'b1;
    ndone = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) ndone++;
    end
    nvec++;
    if (ndone !== 0) begin
      nerr++;
      $display("FAIL midrst_no_done: got %0d busy/done cycles, expected 0", ndone);
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rstn = 1'b0;
    bus.scan_req  = 1'b0;
    bus.threshold = '0;
    clear_mem();
    test_reset();
    test_id0_masked();
    test_hit_word2();
    test_threshold();
    test_high_id();
    test_back_to_back();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/imsic_topei_scanner.md
Name: imsic_topei_scanner

Overview:
Read-side engine for the interrupt-file pending (eip) and enable (eie) word arrays. These arrays are held in two dual-port RAM instances that share one read address. On request, the block walks the words in ascending address order through the RAMs' 1-cycle registered read ports. It reports the lowest-numbered interrupt identity that is both pending and enabled and below the threshold (topei), which feeds the hart's external-interrupt signalling and topei CSR read logic.

Parameters:
NumWords, 32, number of 32-bit words per array; interrupt IDs 0..NumWords*32-1
AddrBits, 5, RAM address width; NumWords <= 2**AddrBits
IdBits, 10, identity width; must equal AddrBits+5

Ports:
clk  input  1  single clock; also drives the RAMs' read clock
rstn  input  1  asynchronous active-low reset
scan_req  input  1  level/pulse; request a (re)scan, asserted after any eip/eie/threshold change
threshold  input  IdBits  eithreshold; 0 = no threshold, else only IDs < threshold qualify
raddr  output  AddrBits  read address to both RAMs
eip_rd  input  32  eip RAM read data, valid the cycle after raddr presented
eie_rd  input  32  eie RAM read data, same timing
busy  output  1  scan in progress
done  output  1  one-cycle pulse, result updated
topei  output  IdBits  winning identity, 0 = none
topei_valid  output  1  topei != 0; held between scans

Behaviour:
- Reset (async, rstn low): state IDLE; raddr=0, busy=0, done=0, topei=0, topei_valid=0; rescan flag, word counter and data-valid pipe cleared. Reset mid-scan aborts the scan with no done pulse.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - Enter SCAN when scan_req=1 or the rescan flag is set.
  - On entry: capture threshold into thr_q, clear rescan, cnt=0, busy=1.
- SCAN:
  - raddr=cnt (registered). cnt increments each cycle until NumWords-1, then holds.
  - A 1-cycle-delayed valid bit and index track the word present on eip_rd/eie_rd.
  - When the delayed valid is high for word k: hits = eip_rd & eie_rd.
    - Mask bit 0 when k=0 (ID 0 never valid).
    - When thr_q != 0, mask every bit whose ID {k,bit} >= thr_q.
  - First nonzero masked word: ID = {k, index of lowest set bit}. Register topei=ID and topei_valid=1, then go to DONE; remaining in-flight reads are discarded.
  - If word NumWords-1 is checked with no hit: topei=0, topei_valid=0, go to DONE.
- DONE (1 cycle): done=1, busy=0, then return to IDLE.
- Latency, with scan_req sampled in cycle 0:
  - raddr=0 in cycle 1; word 0 checked in cycle 2.
  - Hit in word k: done in cycle k+3.
  - No hit: done in cycle NumWords+2.
- Simultaneous events:
  - scan_req=1 during SCAN or DONE sets rescan; the current scan still completes and reports.
  - With rescan set, IDLE re-enters SCAN on the very next cycle, so there is exactly one idle cycle between scans.
  - Multiple requests while busy collapse into one rescan.
- threshold changes mid-scan have no effect on that scan (thr_q is frozen); software must raise scan_req.
- topei/topei_valid change only in the cycle done is asserted.

Test Plan:
- Reset, no request -> all outputs 0; assert rstn mid-scan -> busy=0 immediately, no done, topei=0.
- eip[0]=0x0000_0001, eie all ones, scan_req pulse cycle 0 -> ID 0 masked, no other hit; done in cycle 34 (NumWords=32), topei=0, topei_valid=0.
- eip[2]=eie[2]=0x0001_0100 -> done in cycle 5, topei=72 (2*32+8), topei_valid=1; raddr never exceeds 3.
- Same data, threshold=70 -> topei=0 after full scan; threshold=73 -> topei=72; threshold=72 -> topei=0.
- eip[5] bit3 pending but eie[5]=0, eip[31] bit31 pending and enabled -> topei=1023, done in cycle 34.
- scan_req pulsed during SCAN after changing eip -> first done reports old-data result; second scan starts the cycle after IDLE and reports new result; three extra pulses while busy -> exactly two done pulses total.
